// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM: duty width, duty clamp,
// and the count direction used by the centre-aligned build.
package pwm_pkg;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } cnt_dir_e;

  function automatic int unsigned duty_width(input int unsigned period);
    return $clog2(period + 1);
  endfunction

  function automatic int unsigned clamp_duty(input int unsigned value,
                                             input int unsigned lo,
                                             input int unsigned hi);
    if (value < lo) return lo;
    if (value > hi) return hi;
    return value;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: clamped shadow register with pending flag, active duty
// loaded on period boundaries (or at once while stopped), registered compare.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned DW         = 7,
  parameter int unsigned RESET_DUTY = 20,
  parameter int unsigned MIN_DUTY   = 0,
  parameter int unsigned MAX_DUTY   = 100
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run_i,
  input  logic          oe_i,
  input  logic          load_i,
  input  logic [DW-1:0] cnt_i,
  input  logic [DW-1:0] duty_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic          out_o
);

  logic [DW-1:0] shadow_q, shadow_d;
  logic [DW-1:0] active_q, active_d;
  logic [DW-1:0] duty_clamped;
  logic          pending_q, pending_d;
  logic          out_q, out_d;
  logic          accept;

  assign duty_clamped = DW'(clamp_duty(32'(duty_i), MIN_DUTY, MAX_DUTY));
  assign accept       = valid_i & ~pending_q;

  // Load only fires with pending set and accept only with it clear, so a
  // request taken on a boundary cycle waits for the following boundary.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (load_i && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      shadow_d  = duty_clamped;
      pending_d = 1'b1;
    end
    out_d = run_i & oe_i & (cnt_i < active_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= DW'(RESET_DUTY);
      active_q  <= DW'(RESET_DUTY);
      pending_q <= 1'b0;
      out_q     <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      out_q     <= out_d;
    end
  end

  assign ready_o = ~pending_q;
  assign out_o   = out_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaler, period counter and period_start pulse.
// Define PWM_MULTI_CENTER_EN for centre-aligned (up/down) counting.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter  int unsigned N_CH       = 4,
  parameter  int unsigned CLK_SCALER = 100,
  parameter  int unsigned PERIOD     = 100,
  parameter  int unsigned RESET_DUTY = 20,
  parameter  int unsigned MIN_DUTY   = 0,
  parameter  int unsigned MAX_DUTY   = PERIOD,
  localparam int unsigned DW         = duty_width(PERIOD)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [N_CH-1:0]    oe,
  input  logic [N_CH*DW-1:0] duty_cycle,
  input  logic [N_CH-1:0]    duty_valid,
  output logic [N_CH-1:0]    duty_ready,
  output logic               period_start,
  output logic [N_CH-1:0]    out
);

  localparam int unsigned PW = (CLK_SCALER > 1) ? $clog2(CLK_SCALER) : 1;

  if (!(MIN_DUTY <= RESET_DUTY && RESET_DUTY <= MAX_DUTY && MAX_DUTY <= PERIOD
        && PERIOD >= 2 && CLK_SCALER >= 1 && N_CH >= 1 && N_CH <= 32)) begin : g_bad_cfg
    $error("pwm_multi: need MIN_DUTY<=RESET_DUTY<=MAX_DUTY<=PERIOD, PERIOD>=2, CLK_SCALER>=1, N_CH in 1..32");
  end

  logic [PW-1:0] psc_q, psc_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          period_start_q;
  logic          tick;
  logic          boundary;
  logic          load;

  assign tick = run & (psc_q == PW'(CLK_SCALER - 1));

  always_comb begin
    psc_d = '0;
    if (run && !tick) psc_d = psc_q + 1'b1;
  end

`ifdef PWM_MULTI_CENTER_EN
  cnt_dir_e dir_q, dir_d;

  always_comb begin
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    boundary = 1'b0;
    if (!run) begin
      cnt_d = '0;
      dir_d = UP;
    end else if (tick) begin
      if (dir_q == UP) begin
        if (cnt_q == DW'(PERIOD - 1)) begin
          cnt_d = DW'(PERIOD - 2);
          // With PERIOD==2 the turnaround step already lands on 0.
          if (PERIOD == 2) boundary = 1'b1;
          else             dir_d    = DOWN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == DW'(1)) begin
          boundary = 1'b1;
          dir_d    = UP;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dir_q <= UP;
    else        dir_q <= dir_d;
  end
`else
  always_comb begin
    cnt_d    = cnt_q;
    boundary = 1'b0;
    if (!run) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == DW'(PERIOD - 1)) begin
        cnt_d    = '0;
        boundary = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q          <= '0;
      cnt_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      psc_q          <= psc_d;
      cnt_q          <= cnt_d;
      period_start_q <= boundary;
    end
  end

  assign period_start = period_start_q;
  // While stopped, pending duties go live on the next clock.
  assign load = boundary | ~run;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    pwm_channel #(
      .DW        (DW),
      .RESET_DUTY(RESET_DUTY),
      .MIN_DUTY  (MIN_DUTY),
      .MAX_DUTY  (MAX_DUTY)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .run_i  (run),
      .oe_i   (oe[gi]),
      .load_i (load),
      .cnt_i  (cnt_q),
      .duty_i (duty_cycle[gi*DW +: DW]),
      .valid_i(duty_valid[gi]),
      .ready_o(duty_ready[gi]),
      .out_o  (out[gi])
    );
  end

endmodule
